router_merge: RTL and testbench



---
 rtl/router_merge.sv | 96 +++++++++
 tb/tb_router_merge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_merge.sv
// Four-to-one merge: a one-entry buffer per source, a round-robin arbiter and a
// valid/ready output register that tags each word with its source port index.
module router_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [3:0]            din_en,
  output logic [3:0]            din_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_addr,
  output logic                  dout_en,
  input  logic                  dout_rdy
);

  logic [3:0]            buf_v;
  logic [DATA_WIDTH-1:0] buf_d [4];
  logic [DATA_WIDTH-1:0] din_sel [4];
  logic [1:0]            ptr;
  logic [3:0]            grant;
  logic [1:0]            grant_idx;
  logic                  grant_any;
  logic [1:0]            cand;
  logic                  out_load;
  logic [3:0]            accept;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [1:0]            addr_p1;

  assign din_sel[0] = din0;
  assign din_sel[1] = din1;
  assign din_sel[2] = din2;
  assign din_sel[3] = din3;

  // Rotating priority: the port after the last winner first, the last winner last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!grant_any && buf_v[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  assign out_load = ~vld_p1 | dout_rdy;
  assign din_rdy  = ~buf_v | (grant & {4{out_load}});
  assign accept   = din_en & din_rdy;

  // Stage p0 -> p1 control: buffer occupancy, arbiter pointer, output valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_v  <= '0;
      ptr    <= 2'd3;
      vld_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i])
          buf_v[i] <= 1'b1;
        else if (grant[i] && out_load)
          buf_v[i] <= 1'b0;
      end
      if (out_load) begin
        vld_p1 <= grant_any;
        if (grant_any)
          ptr <= grant_idx;
      end
    end
  end

  // Stage p0 -> p1 data: buffer contents and output word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i])
        buf_d[i] <= din_sel[i];
    end
    if (out_load && grant_any) begin
      data_p1 <= buf_d[grant_idx];
      addr_p1 <= grant_idx;
    end
  end

  assign dout_en   = vld_p1;
  assign dout      = vld_p1 ? data_p1 : '0;
  assign dout_addr = vld_p1 ? addr_p1 : '0;

endmodule

// File: tb/tb_router_merge.sv
// Bench for router_merge: directed vector table, hand-written corner sequences
// and random traffic, all compared against a transaction-level reference model.
module tb_router_merge;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din0, din1, din2, din3;
  logic [3:0]    din_en;
  logic [3:0]    din_rdy;
  logic [DW-1:0] dout;
  logic [1:0]    dout_addr;
  logic          dout_en;
  logic          dout_rdy;

  router_merge #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .din_en(din_en), .din_rdy(din_rdy),
    .dout(dout), .dout_addr(dout_addr), .dout_en(dout_en), .dout_rdy(dout_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] drv [4];

  // Reference model: what each source holds, the last winner, and the output word.
  logic [3:0]    m_bv;
  logic [DW-1:0] m_bd [4];
  int            m_last;
  logic          m_ov;
  logic [DW-1:0] m_od;
  int            m_oa;

  logic [3:0]    obs_rdy;
  logic          obs_en;
  logic [1:0]    obs_addr;
  logic [DW-1:0] obs_dout;

  typedef struct packed {
    logic [3:0]  en;
    logic        rdy;
    logic [31:0] base;
    logic [3:0]  x_rdy;
    logic        x_en;
    logic [1:0]  x_addr;
    logic [31:0] x_dout;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bv   = '0;
    m_last = 3;
    m_ov   = 1'b0;
    m_od   = '0;
    m_oa   = 0;
  endtask

  // Drive one cycle from a negedge, compare against the model, then advance it.
  task automatic cycle(input logic [3:0] en, input logic rdy);
    logic [3:0] mrdy;
    logic       mload;
    int         g;
    din0 = drv[0]; din1 = drv[1]; din2 = drv[2]; din3 = drv[3];
    din_en   = en;
    dout_rdy = rdy;
    #1;
    obs_rdy  = din_rdy;
    obs_en   = dout_en;
    obs_addr = dout_addr;
    obs_dout = dout;
    mload = !m_ov || rdy;
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && m_bv[(m_last + k) % 4]) g = (m_last + k) % 4;
    for (int i = 0; i < 4; i++) mrdy[i] = !m_bv[i] || (g == i && mload);
    chk("dout_en",   32'(obs_en),   32'(m_ov));
    chk("dout_addr", 32'(obs_addr), m_ov ? 32'(m_oa) : 32'(0));
    chk("dout",      obs_dout,      m_ov ? m_od : 32'(0));
    chk("din_rdy",   32'(obs_rdy),  32'(mrdy));
    @(posedge clk);
    if (mload) begin
      if (g >= 0) begin
        m_od = m_bd[g]; m_oa = g; m_ov = 1'b1; m_bv[g] = 1'b0; m_last = g;
      end else begin
        m_ov = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++)
      if (en[i] && mrdy[i]) begin
        m_bv[i] = 1'b1;
        m_bd[i] = drv[i];
      end
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    din_en   = 4'($urandom);
    dout_rdy = 1'($urandom);
    din0 = $urandom; din1 = $urandom; din2 = $urandom; din3 = $urandom;
    #1;
    chk("rst_dout_en",   32'(dout_en),   32'(0));
    chk("rst_dout",      dout,           32'(0));
    chk("rst_dout_addr", 32'(dout_addr), 32'(0));
    chk("rst_din_rdy",   32'(din_rdy),   32'hf);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_en",  32'(dout_en), 32'(0));
    chk("rst_hold_rdy", 32'(din_rdy), 32'hf);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int exp_addr;
    int seqn [4];
    int exp_seq [4];
    int n, first, last;

    tbl[0]  = '{4'b0100, 1'b1, 32'hA5A5_0000, 4'b1111, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b1, 2'd2, 32'hA5A5_0002};
    tbl[3]  = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b0, 2'd0, 32'h0};
    tbl[4]  = '{4'b1001, 1'b1, 32'hB000_0000, 4'b1111, 1'b0, 2'd0, 32'h0};
    tbl[5]  = '{4'b0000, 1'b1, 32'h0,         4'b1110, 1'b0, 2'd0, 32'h0};
    tbl[6]  = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b1, 2'd3, 32'hB000_0003};
    tbl[7]  = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b1, 2'd0, 32'hB000_0000};
    tbl[8]  = '{4'b1111, 1'b0, 32'hC000_0000, 4'b1111, 1'b0, 2'd0, 32'h0};
    tbl[9]  = '{4'b1111, 1'b0, 32'hC100_0000, 4'b0010, 1'b0, 2'd0, 32'h0};
    tbl[10] = '{4'b1111, 1'b0, 32'hC200_0000, 4'b0000, 1'b1, 2'd1, 32'hC000_0001};
    tbl[11] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 1'b1, 2'd1, 32'hC000_0001};
    tbl[12] = '{4'b0000, 1'b1, 32'h0,         4'b0100, 1'b1, 2'd1, 32'hC000_0001};
    tbl[13] = '{4'b0000, 1'b0, 32'h0,         4'b0100, 1'b1, 2'd2, 32'hC000_0002};
    tbl[14] = '{4'b0000, 1'b1, 32'h0,         4'b1100, 1'b1, 2'd2, 32'hC000_0002};
    tbl[15] = '{4'b0000, 1'b1, 32'h0,         4'b1101, 1'b1, 2'd3, 32'hC000_0003};
    tbl[16] = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b1, 2'd0, 32'hC000_0000};
    tbl[17] = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b1, 2'd1, 32'hC100_0001};
    tbl[18] = '{4'b0000, 1'b1, 32'h0,         4'b1111, 1'b0, 2'd0, 32'h0};

    resetn = 1'b0; din_en = '0; dout_rdy = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    for (int i = 0; i < 4; i++) drv[i] = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed table: single word latency, rotation from port 2, back-pressure.
    for (int r = 0; r < 19; r++) begin
      for (int i = 0; i < 4; i++) drv[i] = tbl[r].base + 32'(i);
      cycle(tbl[r].en, tbl[r].rdy);
      chk($sformatf("tbl%0d_rdy", r),  32'(obs_rdy),  32'(tbl[r].x_rdy));
      chk($sformatf("tbl%0d_en", r),   32'(obs_en),   32'(tbl[r].x_en));
      chk($sformatf("tbl%0d_addr", r), 32'(obs_addr), 32'(tbl[r].x_addr));
      chk($sformatf("tbl%0d_dout", r), obs_dout,      tbl[r].x_dout);
    end

    // Round-robin with all four sources saturated.
    do_reset();
    exp_addr = 0;
    for (int i = 0; i < 4; i++) begin seqn[i] = 0; exp_seq[i] = 0; end
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < 4; i++) drv[i] = 32'h1000_0000 + 32'(i) + (32'(seqn[i]) << 8);
      cycle(4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) if (obs_rdy[i]) seqn[i]++;
      if (c >= 2) begin
        chk("rr_en",   32'(obs_en),   32'(1));
        chk("rr_addr", 32'(obs_addr), 32'(exp_addr));
        chk("rr_seq",  32'(obs_dout[15:8]), 32'(exp_seq[exp_addr]));
        exp_seq[exp_addr]++;
        exp_addr = (exp_addr + 1) % 4;
      end
    end
    for (int i = 0; i < 4; i++) drv[i] = '0;
    for (int c = 0; c < 6; c++) cycle(4'b0000, 1'b1);

    // Single source streaming back to back.
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      drv[1] = 32'h2000_0000 + 32'(c);
      cycle(c < 8 ? 4'b0010 : 4'b0000, 1'b1);
      if (c < 8) chk("stream_rdy1", 32'(obs_rdy[1]), 32'(1));
      if (obs_en) begin
        chk("stream_addr", 32'(obs_addr), 32'(1));
        chk("stream_dout", obs_dout, 32'h2000_0000 + 32'(n));
        n++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("stream_count", 32'(n), 32'(8));
    chk("stream_span",  32'(last - first + 1), 32'(8));

    // Reset while buffers are full and the output is held.
    for (int i = 0; i < 4; i++) drv[i] = 32'h3000_0000 + 32'(i);
    for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b0);
    chk("pre_rst_en", 32'(obs_en), 32'(1));
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0000, 1'b1);
      chk("post_rst_idle", 32'(obs_en), 32'(0));
    end
    for (int i = 0; i < 4; i++) drv[i] = 32'h4000_0000 + 32'(i);
    cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("post_rst_first_addr", 32'(obs_addr), 32'(0));
    chk("post_rst_first_dout", obs_dout, 32'h4000_0000);
    for (int c = 0; c < 6; c++) cycle(4'b0000, 1'b1);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) drv[i] = $urandom;
      cycle(4'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 8; c++) cycle(4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
